// File: rtl/whirlpool_wcipher_core.sv
// Iterative Whirlpool W-cipher with optional Miyaguchi-Preneel feed-forward.
// One gamma->pi->theta round per clock for the key schedule and the data state in parallel.

module whirlpool_wcipher_round (
    input  logic [511:0] din,
    output logic [511:0] dout
);

    function automatic logic [3:0] e_box(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h1;  4'h1: y = 4'hb;  4'h2: y = 4'h9;  4'h3: y = 4'hc;
            4'h4: y = 4'hd;  4'h5: y = 4'h6;  4'h6: y = 4'hf;  4'h7: y = 4'h3;
            4'h8: y = 4'he;  4'h9: y = 4'h8;  4'ha: y = 4'h7;  4'hb: y = 4'h4;
            4'hc: y = 4'ha;  4'hd: y = 4'h2;  4'he: y = 4'h5;  4'hf: y = 4'h0;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] ei_box(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hf;  4'h1: y = 4'h0;  4'h2: y = 4'hd;  4'h3: y = 4'h7;
            4'h4: y = 4'hb;  4'h5: y = 4'he;  4'h6: y = 4'h5;  4'h7: y = 4'ha;
            4'h8: y = 4'h9;  4'h9: y = 4'h2;  4'ha: y = 4'hc;  4'hb: y = 4'h1;
            4'hc: y = 4'h3;  4'hd: y = 4'h4;  4'he: y = 4'h8;  4'hf: y = 4'h6;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] r_box(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h7;  4'h1: y = 4'hc;  4'h2: y = 4'hb;  4'h3: y = 4'hd;
            4'h4: y = 4'he;  4'h5: y = 4'h4;  4'h6: y = 4'h9;  4'h7: y = 4'hf;
            4'h8: y = 4'h6;  4'h9: y = 4'h3;  4'ha: y = 4'h8;  4'hb: y = 4'ha;
            4'hc: y = 4'h2;  4'hd: y = 4'h5;  4'he: y = 4'h1;  4'hf: y = 4'h0;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // The 8-bit S-box is built from the E, E^-1 and R mini-boxes instead of a 256-entry table
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        a = e_box(x[7:4]);
        b = ei_box(x[3:0]);
        r = r_box(a ^ b);
        return {e_box(a ^ r), ei_box(b ^ r)};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? x : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    // First row of the circulant diffusion matrix cir(1,1,4,1,8,5,2,9)
    function automatic logic [3:0] theta_coef(input logic [2:0] n);
        logic [3:0] c;
        case (n)
            3'd0: c = 4'd1;  3'd1: c = 4'd1;  3'd2: c = 4'd4;  3'd3: c = 4'd1;
            3'd4: c = 4'd8;  3'd5: c = 4'd5;  3'd6: c = 4'd2;  3'd7: c = 4'd9;
            default: c = 4'd1;
        endcase
        return c;
    endfunction

    // Byte (row i, column j) lives at bits [511-8*(8i+j) -: 8]; pi shifts column j down by j
    function automatic logic [511:0] round_fn(input logic [511:0] a);
        logic [7:0]   p [8][8];
        logic [7:0]   acc;
        logic [511:0] b;
        b = 512'h0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                p[i][j] = sbox(a[511 - 8 * (8 * int'(3'(i - j)) + j) -: 8]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                acc = 8'h00;
                for (int k = 0; k < 8; k++) begin
                    acc = acc ^ gmul(p[i][k], theta_coef(3'(j - k)));
                end
                b[511 - 8 * (8 * i + j) -: 8] = acc;
            end
        end
        return b;
    endfunction

    // Pure combinational round
    always_comb begin
        dout = round_fn(din);
    end

endmodule

module whirlpool_wcipher_core #(
    parameter int ROUNDS      = 10,
    parameter bit MP_FEEDBACK = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_key,
    input  logic [511:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [3:0] LAST_RND = 4'(ROUNDS);

    state_t       state_r;
    state_t       state_s;
    logic [511:0] k_r;
    logic [511:0] s_r;
    logic [511:0] hm_s;
    logic [511:0] out_data_r;
    logic [3:0]   rcnt_r;
    logic         out_valid_r;
    logic         busy_r;
    logic [511:0] rc_s;
    logic [511:0] round_k_s;
    logic [511:0] round_s_s;
    logic [511:0] next_k_s;
    logic [511:0] next_s_s;
    logic         accept_s;
    logic         last_s;

    // RC[r] row 0 = S-box bytes 8(r-1)..8r-1
    function automatic logic [63:0] rc_rom(input logic [3:0] r);
        logic [63:0] v;
        case (r)
            4'd1:    v = 64'h1823c6e887b8014f;
            4'd2:    v = 64'h36a6d2f5796f9152;
            4'd3:    v = 64'h60bc9b8ea30c7b35;
            4'd4:    v = 64'h1de0d7c22e4bfe57;
            4'd5:    v = 64'h157737e59ff04ada;
            4'd6:    v = 64'h58c9290ab1a06b85;
            4'd7:    v = 64'hbd5d10f4cb3e0567;
            4'd8:    v = 64'he427418ba77d95d8;
            4'd9:    v = 64'hfbee7c66dd17479e;
            4'd10:   v = 64'hca2dbf07ad5a8333;
            default: v = 64'h0;
        endcase
        return v;
    endfunction

    whirlpool_wcipher_round u_round_k (.din(k_r), .dout(round_k_s));
    whirlpool_wcipher_round u_round_s (.din(s_r), .dout(round_s_s));

    assign in_ready  = (state_r == IDLE) | ((state_r == DONE) & out_ready);
    assign accept_s  = in_valid & in_ready;
    assign last_s    = (state_r == RUN) && (rcnt_r == LAST_RND);
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;

    // Sigma step: round key and round constant, the ROM is only read while running
    always_comb begin
        rc_s = 512'h0;
        if (state_r == RUN) begin
            rc_s = {rc_rom(rcnt_r), 448'h0};
        end else begin
            rc_s = 512'h0;
        end
        next_k_s = round_k_s ^ rc_s;
        next_s_s = round_s_s ^ next_k_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = RUN;
                else          state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = DONE;
                else        state_s = RUN;
            end
            DONE: begin
                if (accept_s)       state_s = RUN;
                else if (out_ready) state_s = IDLE;
                else                state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, key schedule, data state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            k_r         <= 512'h0;
            s_r         <= 512'h0;
            rcnt_r      <= 4'd0;
            out_data_r  <= 512'h0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            if (accept_s) begin
                k_r         <= in_key;
                s_r         <= in_block ^ in_key;
                rcnt_r      <= 4'd1;
                out_valid_r <= 1'b0;
            end else if (state_r == RUN) begin
                k_r <= next_k_s;
                s_r <= next_s_s;
                if (last_s) begin
                    out_data_r  <= next_s_s ^ hm_s;
                    out_valid_r <= 1'b1;
                end else begin
                    rcnt_r <= rcnt_r + 4'd1;
                end
            end else if ((state_r == DONE) && out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    if (MP_FEEDBACK) begin : g_mp
        logic [511:0] hm_r;

        // Feed-forward term H ^ m captured at accept
        always_ff @(posedge clk or posedge rst) begin
            if (rst)           hm_r <= 512'h0;
            else if (accept_s) hm_r <= in_key ^ in_block;
            else               hm_r <= hm_r;
        end

        assign hm_s = hm_r;
    end else begin : g_no_mp
        assign hm_s = 512'h0;
    end

endmodule

// File: tb/tb_whirlpool_wcipher_core.sv
// Scoreboard bench for whirlpool_wcipher_core: full-round compression DUT plus a 1-round raw-cipher DUT.

module tb_whirlpool_wcipher_core;

    localparam logic [511:0] EMPTY_BLK = {8'h80, 504'h0};
    localparam logic [511:0] EMPTY_DIG = 512'h19FA61D75522A4669B44E39C1D2E1726C530232130D407F89AFEE0964997F7A73E83BE698B288FEBCF88E3E03C4F0757EA8964E59B63D93708B138CC42A66EB3;
    localparam logic [511:0] A_BLK     = {8'h61, 8'h80, 488'h0, 8'h08};
    localparam logic [511:0] A_DIG     = 512'h8ACA2602792AEC6F11A67206531FB7D7F0DFF59413145E6973C45001D0087B42D11BC645413AEFF63A42391A39145A591A92200D560195E53B478584FDAE231A;
    localparam logic [511:0] RC1_ROW   = {64'h1823c6e887b8014f, 448'h0};
    localparam logic [511:0] KEY_X     = {16{32'hdeadbeef}};

    typedef struct {
        string        name;
        logic [511:0] act;
        logic [511:0] exp;
    } req_t;

    logic         clk;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [511:0] in_key, in_block, out_data;
    logic         in_valid_d, in_ready_d, out_valid_d, out_ready_d, busy_d;
    logic [511:0] in_key_d, in_block_d, out_data_d;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [511:0] exp_q [$];
    logic [511:0] exp_d_q [$];
    req_t         req_q [$];
    req_t         mon_r;

    whirlpool_wcipher_core dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_key(in_key), .in_block(in_block), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    whirlpool_wcipher_core #(.ROUNDS(1), .MP_FEEDBACK(1'b0)) dut_dbg (
        .clk(clk), .rst(rst), .in_valid(in_valid_d), .in_ready(in_ready_d),
        .in_key(in_key_d), .in_block(in_block_d), .out_valid(out_valid_d),
        .out_ready(out_ready_d), .out_data(out_data_d), .busy(busy_d)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Monitor: drains direct-check requests and scores every output handshake
    always @(negedge clk) begin
        while (req_q.size() > 0) begin
            mon_r = req_q.pop_front();
            do_check(mon_r.name, mon_r.act, mon_r.exp);
        end
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) do_check("out_extra", 512'(exp_q.size()), 512'h1);
            else                   do_check("out_data", out_data, exp_q.pop_front());
        end
        if (!rst && out_valid_d && out_ready_d) begin
            if (exp_d_q.size() == 0) do_check("dbg_out_extra", 512'(exp_d_q.size()), 512'h1);
            else                     do_check("dbg_out_data", out_data_d, exp_d_q.pop_front());
        end
    end

    function automatic void push(input string nm, input logic [511:0] act, input logic [511:0] exp);
        req_t r;
        r.name = nm;
        r.act  = act;
        r.exp  = exp;
        req_q.push_back(r);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int c);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        if (!out_valid) push("valid_timeout", 512'(out_valid), 512'h1);
        c = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        int c1;
        int c2;
        clk = 1'b0; rst = 1'b1;
        in_valid = 1'b0; in_key = 512'h0; in_block = 512'h0; out_ready = 1'b1;
        in_valid_d = 1'b0; in_key_d = 512'h0; in_block_d = 512'h0; out_ready_d = 1'b1;
        step(); step();
        push("rst_out_valid", 512'(out_valid), 512'h0);
        push("rst_busy", 512'(busy), 512'h0);
        push("rst_in_ready", 512'(in_ready), 512'h1);
        push("rst_out_data", out_data, 512'h0);
        push("rst_dbg_in_ready", 512'(in_ready_d), 512'h1);
        push("rst_dbg_out_data", out_data_d, 512'h0);
        rst = 1'b0;
        step();

        // Empty-message digest, exact latency, then backpressure
        in_key = 512'h0; in_block = EMPTY_BLK; in_valid = 1'b1; out_ready = 1'b0;
        exp_q.push_back(EMPTY_DIG);
        step();
        push("acc_busy", 512'(busy), 512'h1);
        push("acc_in_ready", 512'(in_ready), 512'h0);
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            push("lat_early", 512'(out_valid), 512'h0);
        end
        step();
        push("lat_valid", 512'(out_valid), 512'h1);
        for (int i = 0; i < 20; i++) begin
            step();
            push("bp_data", out_data, EMPTY_DIG);
            push("bp_valid", 512'(out_valid), 512'h1);
            push("bp_in_ready", 512'(in_ready), 512'h0);
        end
        out_ready = 1'b1;
        #1;
        push("done_in_ready", 512'(in_ready), 512'h1);
        step();
        push("drain_busy", 512'(busy), 512'h0);
        push("drain_valid", 512'(out_valid), 512'h0);
        push("drain_in_ready", 512'(in_ready), 512'h1);

        // Back-to-back: second block accepted on the draining edge
        in_key = 512'h0; in_block = EMPTY_BLK; in_valid = 1'b1;
        exp_q.push_back(EMPTY_DIG);
        exp_q.push_back(A_DIG);
        step();
        in_block = A_BLK;
        wait_valid(c1);
        step();
        push("b2b_busy", 512'(busy), 512'h1);
        push("b2b_valid_drop", 512'(out_valid), 512'h0);
        in_valid = 1'b0;
        wait_valid(c2);
        push("b2b_spacing", 512'(c2 - c1), 512'd11);
        step();
        push("b2b_idle", 512'(busy), 512'h0);

        // New data pulsed during RUN must be ignored
        in_key = 512'h0; in_block = EMPTY_BLK; in_valid = 1'b1;
        exp_q.push_back(EMPTY_DIG);
        step();
        in_valid = 1'b0;
        step(); step(); step();
        in_valid = 1'b1; in_key = KEY_X; in_block = A_BLK;
        step();
        in_valid = 1'b0; in_key = 512'h0;
        wait_valid(c1);
        step();
        push("pulse_idle", 512'(busy), 512'h0);

        // Asynchronous reset mid-RUN
        in_block = EMPTY_BLK; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step(); step();
        #2;
        rst = 1'b1;
        #1;
        push("abort_out_valid", 512'(out_valid), 512'h0);
        push("abort_busy", 512'(busy), 512'h0);
        push("abort_in_ready", 512'(in_ready), 512'h1);
        push("abort_out_data", out_data, 512'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            push("abort_no_valid", 512'(out_valid), 512'h0);
        end

        // Recovery with the one-byte message "a"
        in_key = 512'h0; in_block = A_BLK; in_valid = 1'b1;
        exp_q.push_back(A_DIG);
        step();
        in_valid = 1'b0;
        wait_valid(c1);
        step();

        // One raw round from zero block: output is RC[1] in row 0 for any key
        in_key_d = 512'h0; in_block_d = 512'h0; in_valid_d = 1'b1;
        exp_d_q.push_back(RC1_ROW);
        step();
        in_key_d = KEY_X;
        exp_d_q.push_back(RC1_ROW);
        step();
        push("dbg_lat", 512'(out_valid_d), 512'h1);
        step();
        in_valid_d = 1'b0;
        step();
        push("dbg_lat2", 512'(out_valid_d), 512'h1);
        step();
        push("dbg_idle", 512'(busy_d), 512'h0);

        step(); step();
        push("exp_q_empty", 512'(exp_q.size()), 512'h0);
        push("exp_d_q_empty", 512'(exp_d_q.size()), 512'h0);
        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
